mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one unified memory bus port between the fetch stage (IF) and the memory stage (MEM) of the 5-stage pipeline. Arbitrates the two requesters and holds a bus transaction until `bus_ack`. Produces per-stage stall signals that are combined with the hazard unit's stalls. A watchdog terminates hung bus transactions.

Parameters:
- ADDR_WIDTH, 32, address width of all address ports.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- MAX_MEM_STREAK, 4, consecutive MEM grants allowed while IF is waiting; range 1..15.
- TIMEOUT_CYCLES, 255, number of GRANT cycles without `bus_ack` before forced completion; must be ≥ 1.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until `if_valid`.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetch data; valid only while `if_valid`=1.
- if_valid  out  1  one-cycle completion for IF.
- mem_req  in  1  load/store request; held until `mem_valid`.
- mem_we  in  1  1 = store.
- mem_addr  in  ADDR_WIDTH  data address.
- mem_wdata  in  DATA_WIDTH  store data.
- mem_be  in  DATA_WIDTH/8  byte enables.
- mem_rdata  out  DATA_WIDTH  load data; valid only while `mem_valid`=1.
- mem_valid  out  1  one-cycle completion for MEM.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  bus write enable.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_wdata  out  DATA_WIDTH  bus write data.
- bus_be  out  DATA_WIDTH/8  bus byte enables.
- bus_ack  in  1  completion strobe from memory.
- bus_rdata  in  DATA_WIDTH  read data; valid with `bus_ack`.
- stall_if  out  1  IF must hold.
- stall_mem  out  1  MEM (and older stages) must hold.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - `bus_req`, `bus_we`, `if_valid`, `mem_valid`, `bus_err` = 0.
  - `bus_addr`, `bus_wdata`, `bus_be`, `if_rdata`, `mem_rdata` = 0.
  - Streak counter and watchdog = 0.
- `rst` asserted mid-transaction: `bus_req` drops immediately and no valid is issued. The requester reissues after reset.
- FSM states: IDLE, GRANT_IF, GRANT_MEM.
- IDLE, arbitration each cycle:
  - No request: stay in IDLE.
  - `mem_req` only: go to GRANT_MEM.
  - `if_req` only: go to GRANT_IF.
  - Both requesting: go to GRANT_MEM, unless streak == MAX_MEM_STREAK, then go to GRANT_IF.
- On the IDLE→GRANT transition, register `bus_we`/`bus_addr`/`bus_wdata`/`bus_be` from the winner:
  - IF grant: `bus_we`=0, `bus_be`=all ones.
  - MEM grant: fields taken from `mem_we`/`mem_addr`/`mem_wdata`/`mem_be`.
- In GRANT_*:
  - `bus_req`=1 and all bus outputs stable; requester input changes are ignored.
- `bus_ack`=1 in GRANT_X:
  - Same cycle: X_valid=1 (combinational) and X_rdata=`bus_rdata` (combinational pass-through; stores return `bus_rdata` unchanged).
  - Next state is IDLE.
  - `bus_req` is low in the following cycle.
- Minimum transaction is 2 cycles: grant cycle plus ack cycle. Back-to-back transactions cost 1 IDLE cycle each.
- `bus_ack` in IDLE is ignored.
- Streak counter:
  - +1 on each MEM grant made while `if_req`=1, saturating at MAX_MEM_STREAK.
  - Cleared on an IF grant, and on a MEM grant made while `if_req`=0.
- Watchdog:
  - Cleared on entering GRANT_*; +1 per GRANT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, force completion: X_valid=1, X_rdata=0, `bus_err` set (sticky until `rst`), next state IDLE.
  - A `bus_ack` arriving in that same cycle wins: normal completion, no error.
- Stalls (combinational):
  - `stall_if` = `if_req` && !`if_valid`.
  - `stall_mem` = `mem_req` && !`mem_valid`.
- Both valids are never asserted in the same cycle.

Decomposition:
- Package `mem_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, GRANT_IF, GRANT_MEM);
  - the `grant_t` enum (GNT_NONE, GNT_IF, GNT_MEM);
  - the localparam for the default all-ones byte enable.
- Sub-module `bus_watchdog` holds the counter with clear/enable inputs and a `timeout` pulse output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Single fetch: `if_req`=1, `if_addr`=0x100, `bus_ack` 3 cycles after grant with `bus_rdata`=0x00500093 -> `bus_req` high 4 cycles, `bus_we`=0, `bus_be`=0xF, `if_valid`/`if_rdata`=0x00500093 on the ack cycle, `stall_if` high until then.
- Store: `mem_req`=1, `mem_we`=1, `mem_addr`=0x2000, `mem_wdata`=0xDEADBEEF, `mem_be`=0x3 -> bus carries exactly those values and they stay stable while ack is delayed 5 cycles; `mem_valid` pulses once.
- Simultaneous requests, both held, ack always 1 cycle after grant, MAX_MEM_STREAK=4 -> grant order MEM,MEM,MEM,MEM,IF,MEM…; IF never waits more than 4 MEM grants.
- Timeout, TIMEOUT_CYCLES=8: MEM load with no ack -> after 8 GRANT cycles `mem_valid`=1, `mem_rdata`=0, `bus_err`=1 and stays 1; next request proceeds normally.
- Reset mid-transaction: assert `rst` 2 cycles into a GRANT_IF -> `bus_req`=0 same cycle, no `if_valid`, FSM in IDLE; after release, held `if_req` is granted again.
- Ack/timeout tie: ack arrives exactly on cycle TIMEOUT_CYCLES -> `if_rdata`=`bus_rdata`, `bus_err` stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IF  = 2'd1,
        GRANT_MEM = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

    // Fetches always read a full word; sliced down to DATA_WIDTH/8 at the user.
    localparam int MAX_BE_WIDTH = 64;
    localparam logic [MAX_BE_WIDTH-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, bus and stall signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    if_req;
    logic [ADDR_WIDTH-1:0]   if_addr;
    logic [DATA_WIDTH-1:0]   if_rdata;
    logic                    if_valid;

    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_valid;

    logic                    bus_req;
    logic                    bus_we;
    logic [ADDR_WIDTH-1:0]   bus_addr;
    logic [DATA_WIDTH-1:0]   bus_wdata;
    logic [DATA_WIDTH/8-1:0] bus_be;
    logic                    bus_ack;
    logic [DATA_WIDTH-1:0]   bus_rdata;

    logic                    stall_if;
    logic                    stall_mem;
    logic                    bus_err;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  bus_ack, bus_rdata,
        output if_rdata, if_valid, mem_rdata, mem_valid,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output stall_if, stall_mem, bus_err
    );

    // Pipeline and memory side
    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output bus_ack, bus_rdata,
        input  if_rdata, if_valid, mem_rdata, mem_valid,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  stall_if, stall_mem, bus_err
    );

endinterface

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// Counts GRANT cycles without ack; timeout pulses in the cycle that would
// bring the count to TIMEOUT_CYCLES.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign timeout = enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !timeout) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory stages onto one memory bus port, with
// MEM-streak fairness, pipeline stalls and a hung-transaction watchdog.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | bus free; arbitrate and latch the winner's bus fields
// GRANT_IF  | fetch transaction on the bus, waiting for ack or timeout
// GRANT_MEM | load/store transaction on the bus, waiting for ack/timeout
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_MEM_STREAK = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave port
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [BE_W-1:0] BE_FULL    = BE_ALL_ONES[BE_W-1:0];
    localparam logic [3:0]      STREAK_MAX = 4'(MAX_MEM_STREAK);

    arb_state_t state, state_next;
    grant_t     grant;

    logic [3:0]            streak, streak_next;
    logic                  timeout, done;
    logic                  bus_we_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q;
    logic [BE_W-1:0]       bus_be_q;
    logic                  bus_err_q;

    // MEM wins ties until it has starved IF for MAX_MEM_STREAK grants.
    always_comb begin
        grant = GNT_NONE;
        if (state == IDLE) begin
            if (port.mem_req && !(port.if_req && (streak == STREAK_MAX))) begin
                grant = GNT_MEM;
            end else if (port.if_req) begin
                grant = GNT_IF;
            end
        end
    end

    always_comb begin
        streak_next = streak;
        if (grant == GNT_IF) begin
            streak_next = '0;
        end else if (grant == GNT_MEM) begin
            if (!port.if_req) begin
                streak_next = '0;
            end else if (streak != STREAK_MAX) begin
                streak_next = streak + 4'd1;
            end
        end
    end

    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  ((state != IDLE) && !port.bus_ack),
        .timeout (timeout)
    );

    assign done = port.bus_ack || timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    // A forced completion returns zero data; a real ack always wins.
    always_comb begin
        state_next     = state;
        port.if_valid  = 1'b0;
        port.if_rdata  = '0;
        port.mem_valid = 1'b0;
        port.mem_rdata = '0;
        unique case (state)
            IDLE: begin
                if (grant == GNT_IF) begin
                    state_next = GRANT_IF;
                end else if (grant == GNT_MEM) begin
                    state_next = GRANT_MEM;
                end
            end
            GRANT_IF: begin
                if (done) begin
                    state_next    = IDLE;
                    port.if_valid = 1'b1;
                    port.if_rdata = port.bus_ack ? port.bus_rdata : '0;
                end
            end
            GRANT_MEM: begin
                if (done) begin
                    state_next     = IDLE;
                    port.mem_valid = 1'b1;
                    port.mem_rdata = port.bus_ack ? port.bus_rdata : '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus fields are captured once per grant so requester changes cannot leak onto the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
        end else if (grant == GNT_IF) begin
            bus_we_q    <= 1'b0;
            bus_addr_q  <= port.if_addr;
            bus_wdata_q <= '0;
            bus_be_q    <= BE_FULL;
        end else if (grant == GNT_MEM) begin
            bus_we_q    <= port.mem_we;
            bus_addr_q  <= port.mem_addr;
            bus_wdata_q <= port.mem_wdata;
            bus_be_q    <= port.mem_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if (timeout) begin
            bus_err_q <= 1'b1;
        end
    end

    assign port.bus_req   = (state != IDLE);
    assign port.bus_we    = bus_we_q;
    assign port.bus_addr  = bus_addr_q;
    assign port.bus_wdata = bus_wdata_q;
    assign port.bus_be    = bus_be_q;
    assign port.bus_err   = bus_err_q;

    assign port.stall_if  = port.if_req && !port.if_valid;
    assign port.stall_mem = port.mem_req && !port.mem_valid;

endmodule
